// File: rtl/mac_step_counter.sv
// ---------------------------------------------------------------------------
// mac_step_counter
//   Step counter that sequences MAC accumulation cycles. Counts enabled steps
//   from 0 up to CNT_NUM inside a frame. It runs either once (MODE=0, stops
//   in DONE) or in free-running wrap mode (MODE=1). It also keeps a
//   saturating count of completed frames.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       asynchronous reset, active-high
//   i_clr       synchronous clear: back to IDLE, counters zeroed
//   i_start     start / restart a frame (count back to 0)
//   i_en        step enable, one MAC cycle completed
//   i_load      preload the count (honoured in RUN only)
//   i_load_val  preload value, clipped to CNT_NUM
//   o_cnt       current count
//   o_cnt_f     level, o_cnt == CNT_NUM
//   o_busy      high while in RUN
//   o_done      one-cycle pulse when a frame completes
//   o_frames    completed frames, saturating
// ---------------------------------------------------------------------------
module mac_step_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned CNT_NUM = 8,
    parameter int unsigned MODE    = 0,
    parameter int unsigned FRAME_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_start,
    input  logic               i_en,
    input  logic               i_load,
    input  logic [WIDTH-1:0]   i_load_val,
    output logic [WIDTH-1:0]   o_cnt,
    output logic               o_cnt_f,
    output logic               o_busy,
    output logic               o_done,
    output logic [FRAME_W-1:0] o_frames
);

    if (CNT_NUM < 1 || CNT_NUM > (2**WIDTH) - 1) begin : g_bad_cnt_num
        $error("mac_step_counter: CNT_NUM must lie in 1..2**WIDTH-1");
    end

    if (MODE > 1) begin : g_bad_mode
        $error("mac_step_counter: MODE must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] CNT_TERM = WIDTH'(CNT_NUM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [FRAME_W-1:0] frames_q, frames_d;
    logic               hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frames_q <= frames_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        frames_d = frames_q;
        hit      = 1'b0;

        if (i_clr) begin
            state_d  = IDLE;
            cnt_d    = '0;
            frames_d = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (i_start) begin
                        cnt_d = '0;
                    end else if (i_load) begin
                        cnt_d = (i_load_val > CNT_TERM) ? CNT_TERM : i_load_val;
                        // A load that leaves the count already sitting at
                        // CNT_NUM is not a new arrival, so it does not pulse.
                        hit   = (cnt_d == CNT_TERM) && (cnt_q != CNT_TERM);
                    end else if (i_en) begin
                        if (cnt_q < CNT_TERM) begin
                            cnt_d = cnt_q + 1'b1;
                            hit   = (cnt_d == CNT_TERM);
                        end else if (MODE == 1) begin
                            cnt_d = '0;
                        end
                    end
                end
                DONE, IDLE: begin
                    if (i_start) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Frame completion: pulse, bump the saturating frame count, and in
        // one-shot mode park in DONE on the same edge.
        if (hit) begin
            done_d = 1'b1;
            if (frames_q != '1) begin
                frames_d = frames_q + 1'b1;
            end
            if (MODE == 0) begin
                state_d = DONE;
            end
        end
    end

    assign busy_d   = (state_d == RUN);

    assign o_cnt    = cnt_q;
    assign o_cnt_f  = (cnt_q == CNT_TERM);
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_frames = frames_q;

endmodule
